load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Executes one LDR/STR/LDRB/STRB memory access per command and sits beside the register file.
- Store data comes from the regfile's str_data read port; load results go back through the regfile's dedicated load write port (w_data_ldr/w_addr_ldr/w_en_ldr).
- Talks to data memory over a simple req/ready handshake with variable latency.
- Reports busy/done/err to the controller FSM.

Parameters:
- ADDR_W, 32, byte address width presented to data memory.
- TIMEOUT_CYCLES, 16, max cycles in REQ before abort; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only in IDLE.
- is_load  in  1  1 = load, 0 = store.
- is_byte  in  1  1 = byte access, 0 = word access.
- addr  in  ADDR_W  effective byte address, computed by the datapath.
- rd_addr  in  4  load destination register index.
- str_data  in  32  store data, from the regfile str_data port.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced to 0).
- mem_be  out  4  byte enables.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid when mem_ready=1.
- mem_ready  in  1  completes the request in the same cycle.
- w_data_ldr  out  32  load result to the regfile.
- w_addr_ldr  out  4  load destination to the regfile.
- w_en_ldr  out  1  one-cycle load write pulse.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.

Behaviour:
- Reset values: all outputs 0; state = IDLE.
  - Reset mid-operation returns the unit to IDLE at that edge; mem_req is low the following cycle.
  - No write-back occurs for the aborted command.
- FSM states: IDLE, REQ, WB.
- IDLE:
  - On start=1, latch is_load, is_byte, addr, rd_addr and str_data, then go to REQ.
  - If the command is a misaligned word access (is_byte=0 and addr[1:0]!=0), go to WB with the error flag set and issue no memory request.
- REQ:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are driven from the latched fields and stay stable until mem_ready.
  - On mem_ready=1: a load captures mem_rdata, then go to WB. The same applies to a store.
- WB (one cycle):
  - done=1.
  - err=1 if the error flag is set.
  - w_en_ldr=1 only if the command is a load, there is no error, and rd_addr!=15. A load to r15 completes, but the write is suppressed.
  - Next state is IDLE.
- Latency: start accepted at cycle 0, mem_req high at cycle 1. If mem_ready=1 at cycle 1, done/w_en_ldr fire at cycle 2. Minimum 3 cycles start-to-start. Each extra wait cycle adds 1.
- A start issued while busy=1 is ignored and not queued.
- start and done coincide only across WB→IDLE. A start in the WB cycle is ignored; the earliest next accept is the cycle after done.
- Word access: mem_be=4'hF, mem_wdata=str_data, load result = mem_rdata.
- Byte access, with lane k = addr[1:0]:
  - mem_be = 1<<k.
  - mem_wdata = str_data[7:0] replicated into all 4 lanes.
  - Load result = {24'b0, mem_rdata[8k+7:8k]} (zero-extend).
- Loads: w_addr_ldr = latched rd_addr; w_data_ldr holds its value until the next load.
- Stores never assert w_en_ldr.
- mem_rdata is ignored outside REQ while mem_ready=0.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ, cleared on entry.
  - If TIMEOUT_CYCLES cycles elapse without mem_ready, drop mem_req and go to WB with the error flag set, so done=1 and err=1 with no write-back.
  - mem_ready arriving in the same cycle the count expires wins: the access completes normally.
- Not defined: no counter; REQ waits indefinitely for mem_ready.

Decomposition:
- Package lsu_pkg holds:
  - the lsu_state_t enum (IDLE/REQ/WB);
  - the byte-enable constants BE_WORD=4'hF and BE_NONE=4'h0;
  - the constant PC_IDX=4'd15.
- Sub-module lsu_lane_align (combinational) holds:
  - the byte-lane extract and zero-extend for loads;
  - store byte replication;
  - mem_be generation.
  Both directions sit in one module so the load and store lane logic are verified together.

Test Plan:
- Word load: start, is_load=1, addr=0x40, rd=3; mem_ready=1 with mem_rdata=0xDEADBEEF on the first REQ cycle -> mem_addr=0x40, mem_be=F, mem_we=0; next cycle w_en_ldr=1, w_addr_ldr=3, w_data_ldr=0xDEADBEEF, done=1, err=0.
- Byte store: addr=0x43, str_data=0x123456AB; mem_ready delayed 3 cycles -> mem_req held 4 cycles, mem_addr=0x40, mem_be=4'b1000, mem_wdata=0xABABABAB, mem_we=1; done after ready; w_en_ldr never set.
- Byte load, lane 2: addr=0x1002, mem_rdata=0x11C3_5577 -> w_data_ldr=0x000000C3.
- Misaligned word: addr=0x41 -> mem_req never asserts; cycle 1 done=1, err=1, w_en_ldr=0.
- Boundary sequence:
  - Load to rd=15: done=1, w_en_ldr=0.
  - A start pulse during REQ is ignored, with exactly one done.
  - rst asserted mid-REQ: mem_req=0 next cycle, busy=0, no done.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: mem_ready held low -> mem_req drops after 4 REQ cycles, then done=1, err=1. A second run with mem_ready asserted on the expiry cycle completes normally with err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } lsu_state_t;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;
  localparam logic [3:0] PC_IDX  = 4'd15;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for both directions: byte enables, store replication, load extract.
// Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        is_byte,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  always_comb begin
    be      = is_byte ? (4'b0001 << lane) : BE_WORD;
    wdata   = is_byte ? {4{st_data[7:0]}} : st_data;
    ld_data = rdata;
    if (is_byte) begin
      unique case (lane)
        2'd0:    ld_data = {24'b0, rdata[7:0]};
        2'd1:    ld_data = {24'b0, rdata[15:8]};
        2'd2:    ld_data = {24'b0, rdata[23:16]};
        default: ld_data = {24'b0, rdata[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// One LDR/STR/LDRB/STRB access per command: IDLE -> REQ (wait mem_ready) -> WB.
// Defining LSU_TIMEOUT_EN aborts a REQ with err after TIMEOUT_CYCLES cycles without mem_ready.
module load_store_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        rd_addr,
  input  logic [31:0]       str_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       w_data_ldr,
  output logic [3:0]        w_addr_ldr,
  output logic              w_en_ldr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import lsu_pkg::*;

  lsu_state_t        st_q, st_d;
  logic              ld_q, byte_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        rd_q;
  logic [31:0]       sdata_q, ldr_q;
  logic [3:0]        be_w;
  logic [31:0]       wdata_w, ld_w;
  logic              misaligned, timeout;

  assign misaligned = !is_byte && (addr[1:0] != 2'b00);

  lsu_lane_align u_align (
    .is_byte (byte_q),
    .lane    (addr_q[1:0]),
    .st_data (sdata_q),
    .rdata   (mem_rdata),
    .be      (be_w),
    .wdata   (wdata_w),
    .ld_data (ld_w)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Cleared whenever we are not in REQ, so each entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst || st_q != REQ) cnt_q <= '0;
    else                    cnt_q <= cnt_q + 1'b1;
  end

  assign timeout = (st_q == REQ) && !mem_ready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (start) st_d = misaligned ? WB : REQ;
      REQ:     if (mem_ready || timeout) st_d = WB;
      WB:      st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q    <= 1'b0;
      byte_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 4'd0;
      sdata_q <= 32'd0;
      ldr_q   <= 32'd0;
    end else begin
      if (st_q == IDLE && start) begin
        ld_q    <= is_load;
        byte_q  <= is_byte;
        addr_q  <= addr;
        rd_q    <= rd_addr;
        sdata_q <= str_data;
        err_q   <= misaligned;
      end
      // Load data is captured even for r15 so w_data_ldr always tracks the last load.
      if (st_q == REQ && mem_ready && ld_q) ldr_q <= ld_w;
      if (timeout) err_q <= 1'b1;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = BE_NONE;
    mem_wdata = 32'd0;
    done      = 1'b0;
    err       = 1'b0;
    w_en_ldr  = 1'b0;
    unique case (st_q)
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = !ld_q;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_be    = be_w;
        mem_wdata = wdata_w;
      end
      WB: begin
        done     = 1'b1;
        err      = err_q;
        w_en_ldr = ld_q && !err_q && (rd_q != PC_IDX);
      end
      default: ;
    endcase
  end

  assign busy       = (st_q != IDLE);
  assign w_data_ldr = ldr_q;
  assign w_addr_ldr = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plan vectors plus randomized commands checked against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, is_byte;
  logic [31:0] addr;
  logic [3:0]  rd_addr;
  logic [31:0] str_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [31:0] w_data_ldr;
  logic [3:0]  w_addr_ldr;
  logic        w_en_ldr, busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_ld = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_byte(is_byte),
    .addr(addr), .rd_addr(rd_addr), .str_data(str_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic scramble_inputs();
    is_load  = 1'($urandom);
    is_byte  = 1'($urandom);
    addr     = $urandom;
    rd_addr  = 4'($urandom);
    str_data = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic do_cmd(input bit ld, input bit byt, input logic [31:0] a, input logic [3:0] rd,
                        input logic [31:0] sd, input int wait_n, input logic [31:0] rdata,
                        input bit poke_req, input bit poke_wb);
    int          k;
    bit          mis;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
    k    = int'(a[1:0]);
    mis  = !byt && (k != 0);
    e_be = byt ? 4'(1 << k) : 4'hF;
    e_wd = byt ? {4{sd[7:0]}} : sd;
    e_ld = byt ? ((rdata >> (8 * k)) & 32'hFF) : rdata;

    start = 1'b1; is_load = ld; is_byte = byt; addr = a; rd_addr = rd; str_data = sd;
    @(negedge clk);
    start = 1'b0;
    if (!mis) begin
      for (int i = 0; i <= wait_n; i++) begin
        check("req", mem_req, 1'b1);
        check("we", mem_we, !ld);
        check("maddr", mem_addr, a & 32'hFFFF_FFFC);
        check("be", mem_be, e_be);
        if (!ld) check("wdata", mem_wdata, e_wd);
        check("done_early", done, 1'b0);
        mem_ready = (i == wait_n);
        mem_rdata = (i == wait_n) ? rdata : $urandom;
        if (poke_req && i == 0) begin
          start = 1'b1;
          scramble_inputs();
        end
        @(negedge clk);
        start = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      if (ld) last_ld = e_ld;
    end
    check("wb_req", mem_req, 1'b0);
    check("wb_done", done, 1'b1);
    check("wb_err", err, mis);
    check("wb_wen", w_en_ldr, ld && !mis && rd != 4'd15);
    if (ld && !mis) check("wb_waddr", w_addr_ldr, rd);
    check("wb_wdata", w_data_ldr, last_ld);
    if (poke_wb) begin
      start = 1'b1;
      scramble_inputs();
    end
    @(negedge clk);
    start = 1'b0;
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
    check("idle_req", mem_req, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_byte = 1'b0; addr = 32'd0;
    rd_addr = 4'd0; str_data = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_wen", w_en_ldr, 1'b0);
    check("rst_wdata", w_data_ldr, 32'd0);
    check("rst_be", mem_be, 4'h0);
    rst = 1'b0;
    @(negedge clk);

    do_cmd(1, 0, 32'h40, 4'd3, 32'd0, 0, 32'hDEADBEEF, 0, 0);
    do_cmd(0, 1, 32'h43, 4'd0, 32'h123456AB, 3, 32'h0, 0, 0);
    do_cmd(1, 1, 32'h1002, 4'd7, 32'd0, 1, 32'h11C35577, 0, 0);
    check("byte_lane2", w_data_ldr, 32'h000000C3);
    do_cmd(1, 0, 32'h41, 4'd2, 32'd0, 0, 32'h0, 0, 1);
    do_cmd(1, 0, 32'h80, 4'd15, 32'd0, 0, 32'hCAFEF00D, 0, 0);
    do_cmd(0, 0, 32'h84, 4'd1, 32'h5A5A1234, 2, 32'h0, 1, 1);

    // Reset while in REQ: unit drops to idle, no completion afterwards.
    start = 1'b1; is_load = 1'b1; is_byte = 1'b0; addr = 32'h100; rd_addr = 4'd4;
    @(negedge clk);
    start = 1'b0;
    check("mid_req", mem_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    last_ld = 32'd0;
    @(negedge clk);
    check("post_rst_done", done, 1'b0);
    check("post_rst_wen", w_en_ldr, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      bit byt;
      byt = 1'($urandom);
      a = $urandom;
      if (!byt && ($urandom_range(0, 2) != 0)) a[1:0] = 2'b00;
      do_cmd(1'($urandom), byt, a, 4'($urandom), $urandom, $urandom_range(0, 2), $urandom,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

`ifdef LSU_TIMEOUT_EN
    start = 1'b1; is_load = 1'b1; is_byte = 1'b0; addr = 32'h200; rd_addr = 4'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_req", mem_req, 1'b1);
      @(negedge clk);
    end
    check("to_req_drop", mem_req, 1'b0);
    check("to_done", done, 1'b1);
    check("to_err", err, 1'b1);
    check("to_wen", w_en_ldr, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to2_req", mem_req, 1'b1);
      mem_ready = (i == 3);
      mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    check("to2_done", done, 1'b1);
    check("to2_err", err, 1'b0);
    check("to2_wen", w_en_ldr, 1'b1);
    check("to2_wdata", w_data_ldr, 32'h0BADF00D);
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
